// File: rtl/bus_pkg.sv
// Shared bus types for the core's initiators and responders.
// Request/response structs plus the address range helper used by memory slaves.
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic                  write;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_request_t;

    typedef struct packed {
        logic                  ack;
        logic                  error;
        logic [BUS_DATA_W-1:0] rdata;
    } bus_response_t;

    // True when every address bit above the word index and byte lanes is zero.
    function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] addr,
                                           input int unsigned           idx_w);
        return ((addr >> (idx_w + 2)) == '0);
    endfunction

endpackage

// File: rtl/responder_pipeline.sv
// Fixed-depth shift register of bus responses; the last stage is the registered
// bus output. A synchronous flush drops everything in flight.
module responder_pipeline
    import bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  bus_response_t i_resp,
    output bus_response_t o_resp
);

    bus_response_t r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_resp;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_resp = r_stage[DEPTH-1];

endmodule

// File: rtl/bus_memory_responder.sv
// Pipelined bus slave in front of a single-ported word RAM. Every accepted strobe
// is acknowledged exactly READ_LATENCY cycles later, in order.
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int    DEPTH_WORDS     = 1024,
    parameter int    READ_LATENCY    = 2,
    parameter int    MAX_OUTSTANDING = 2,
    parameter string INIT_FILE       = ""
) (
    input  logic                                       Clock,
    input  logic                                       Reset,
    input  logic                                       BusCycle,
    input  logic                                       BusStrobe,
    input  logic                                       BusReadWrite,
    input  logic [BUS_ADDR_W-1:0]                      MemoryAddress,
    input  logic [BUS_DATA_W-1:0]                      MemoryDataIn,
    output logic                                       BusStall,
    output logic                                       BusAcknowledge,
    output logic                                       BusError,
    output logic [BUS_DATA_W-1:0]                      MemoryDataOut,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       o_outstanding
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [BUS_DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [CNT_W-1:0]      r_outstanding;

    bus_request_t          w_req;
    bus_response_t         w_resp_in;
    bus_response_t         w_resp_out;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_ack_done;

    assign w_req      = '{addr: MemoryAddress, write: BusReadWrite, wdata: MemoryDataIn};
    assign w_idx      = w_req.addr[IDX_W+1:2];
    assign w_in_range = addr_in_range(w_req.addr, IDX_W);
    // Stall is registered-only, so acceptance never depends on this cycle's ack.
    assign w_accept   = BusCycle & BusStrobe & ~BusStall & ~Reset;

    always_ff @(posedge Clock) begin
        if (w_accept && w_req.write && w_in_range) begin
            r_mem[w_idx] <= w_req.wdata;
        end
    end

    // Reads sample the RAM at acceptance; writes and errors carry zero data.
    always_comb begin
        w_resp_in       = '0;
        w_resp_in.ack   = w_accept;
        w_resp_in.error = w_accept & ~w_in_range;
        if (w_accept && !w_req.write && w_in_range) begin
            w_resp_in.rdata = r_mem[w_idx];
        end
    end

    responder_pipeline #(
        .DEPTH (READ_LATENCY)
    ) u_pipeline (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_flush (~BusCycle),
        .i_resp  (w_resp_in),
        .o_resp  (w_resp_out)
    );

    // An aborted cycle must never see an acknowledge, even one already staged.
    assign w_ack_done     = w_resp_out.ack & BusCycle;
    assign BusAcknowledge = w_ack_done;
    assign BusError       = w_resp_out.error & BusCycle;
    assign MemoryDataOut  = w_resp_out.rdata;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_outstanding <= '0;
        end else if (!BusCycle) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_ack_done})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign BusStall      = (r_outstanding == CNT_W'(MAX_OUTSTANDING));
    assign o_outstanding = r_outstanding;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Randomised bench for bus_memory_responder with an expected-response queue
// and a memory model keyed by word index.
module tb_bus_memory_responder;

    localparam int L    = 2;
    localparam int MAXO = 2;
    localparam int MAX1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cyc, a_stb, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        a_stall, a_ack, a_err;
    logic [31:0] a_rdata;
    logic [1:0]  a_outst;
    logic        b_cyc, b_stb, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        b_stall, b_ack, b_err;
    logic [31:0] b_rdata;
    logic [0:0]  b_outst;

    int          cyc_n = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [64:0] exp_q [$];   // {due cycle, error, data}
    int          acc_q [$];   // acceptance cycles of unacknowledged requests
    logic [31:0] mem_m [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    bus_memory_responder #(
        .DEPTH_WORDS(1024), .READ_LATENCY(L), .MAX_OUTSTANDING(MAXO), .INIT_FILE("")
    ) u_dut (
        .Clock(clk), .Reset(rst), .BusCycle(a_cyc), .BusStrobe(a_stb),
        .BusReadWrite(a_we), .MemoryAddress(a_addr), .MemoryDataIn(a_wdata),
        .BusStall(a_stall), .BusAcknowledge(a_ack), .BusError(a_err),
        .MemoryDataOut(a_rdata), .o_outstanding(a_outst)
    );

    bus_memory_responder #(
        .DEPTH_WORDS(1024), .READ_LATENCY(L), .MAX_OUTSTANDING(MAX1), .INIT_FILE("")
    ) u_dut1 (
        .Clock(clk), .Reset(rst), .BusCycle(b_cyc), .BusStrobe(b_stb),
        .BusReadWrite(b_we), .MemoryAddress(b_addr), .MemoryDataIn(b_wdata),
        .BusStall(b_stall), .BusAcknowledge(b_ack), .BusError(b_err),
        .MemoryDataOut(b_rdata), .o_outstanding(b_outst)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Requests still unacknowledged at the start of cycle t (acked at end of c+L).
    function automatic int model_out(input int t, input int lat);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] + lat >= t) n++;
        return n;
    endfunction

    task automatic step(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, output logic acc);
        int   o;
        logic in_rng;
        @(posedge clk);
        #1;
        o = 0;
        while (acc_q.size() > 0 && acc_q[0] + L < cyc_n) void'(acc_q.pop_front());
        if (!rst) begin
            o = model_out(cyc_n, L);
            check("stall", {31'd0, a_stall}, (o == MAXO) ? 32'd1 : 32'd0);
            check("outstanding", {30'd0, a_outst}, o);
        end
        a_cyc = c; a_stb = s; a_we = w; a_addr = a; a_wdata = d;
        acc = c && s && (o != MAXO) && !rst;
        in_rng = (a[31:12] == 20'd0);
        if (!c) begin
            acc_q.delete();
            exp_q.delete();
        end else if (acc) begin
            if (w) begin
                if (in_rng) mem_m[int'(a[11:2])] = d;
                exp_q.push_back({32'(cyc_n + L), ~in_rng, 32'd0});
            end else begin
                exp_q.push_back({32'(cyc_n + L), ~in_rng,
                                 in_rng ? mem_m[int'(a[11:2])] : 32'd0});
            end
            acc_q.push_back(cyc_n);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        int   tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            step(1'b1, 1'b1, w, a, d, acc);
            tries++;
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: got no acceptance expected acceptance within 10 cycles");
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    endtask

    always @(negedge clk) begin : monitor
        logic [64:0] e;
        if (!rst) begin
            if (a_ack) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc_n);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_cycle", cyc_n, e[64:33]);
                    check("error", {31'd0, a_err}, {31'd0, e[32]});
                    check("rdata", a_rdata, e[31:0]);
                end
            end else begin
                check("err_idle", {31'd0, a_err}, 32'd0);
                if (exp_q.size() > 0 && int'(exp_q[0][64:33]) <= cyc_n) begin
                    e = exp_q.pop_front();
                    n_vec++; n_err++;
                    $display("FAIL missing_ack: got none expected ack due cycle %0d", e[64:33]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic        w;
        logic [31:0] a;
        int          o, t, k;
        int          bacc [$];
        logic [64:0] bq [$];
        logic [64:0] e;

        rst = 1'b1;
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        #12;
        check("rst_ack", {31'd0, a_ack}, 32'd0);
        check("rst_err", {31'd0, a_err}, 32'd0);
        check("rst_stall", {31'd0, a_stall}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_outstanding", {30'd0, a_outst}, 32'd0);
        #20 rst = 1'b0;

        // Preload words 0..15, word 5 holding the boot pattern.
        for (int i = 0; i < 16; i++)
            issue(1'b1, 32'(i * 4), (i == 5) ? 32'hDEAD_BEEF : $urandom);
        idle(4);
        issue(1'b0, 32'h14, 32'd0);
        idle(4);

        issue(1'b1, 32'h40, 32'h1234_5678);
        issue(1'b0, 32'h40, 32'd0);
        idle(4);

        issue(1'b0, 32'h1000, 32'd0);
        issue(1'b1, 32'h1000, 32'hA5A5_A5A5);
        issue(1'b0, 32'h0, 32'd0);
        idle(4);

        // Abort with two reads in flight.
        issue(1'b0, 32'h8, 32'd0);
        issue(1'b0, 32'hC, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, acc);
        idle(3);
        issue(1'b0, 32'h10, 32'd0);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0)
                a = {12'($urandom_range(1, 4095)), 20'($urandom)};
            else
                a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            if (!w && a[31:12] == 20'd0 && !mem_m.exists(int'(a[11:2]))) w = 1'b1;
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7), w, a, $urandom, acc);
        end
        idle(6);
        check("drained", exp_q.size(), 32'd0);

        // Asynchronous reset between edges with two reads in flight.
        issue(1'b1, 32'h1C, 32'hCAFE_F00D);
        idle(2);
        issue(1'b0, 32'h4, 32'd0);
        issue(1'b0, 32'h8, 32'd0);
        idle(1);
        #2 rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("arst_ack", {31'd0, a_ack}, 32'd0);
        check("arst_stall", {31'd0, a_stall}, 32'd0);
        check("arst_rdata", a_rdata, 32'd0);
        check("arst_outstanding", {30'd0, a_outst}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        idle(3);
        issue(1'b0, 32'h1C, 32'd0);
        idle(4);

        // Single-slot instance: strobe held, 4 writes then 4 reads.
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            t = cyc_n;
            o = 0;
            foreach (bacc[j]) if (bacc[j] + L >= t) o++;
            check("b_stall", {31'd0, b_stall}, (o == MAX1) ? 32'd1 : 32'd0);
            check("b_outstanding", {31'd0, b_outst}, o);
            b_cyc = 1'b1;
            b_stb = (k < 8);
            b_we = (k < 4);
            b_addr = 32'((k % 4) * 4);
            b_wdata = 32'hC0DE_0000 + 32'(k);
            if (k < 8 && o < MAX1) begin
                bq.push_back({32'(t + L), 1'b0, (k < 4) ? 32'd0 : 32'hC0DE_0000 + 32'(k - 4)});
                bacc.push_back(t);
                k++;
            end
            @(negedge clk);
            if (b_ack) begin
                if (bq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexpected_ack: got ack expected none (cycle %0d)", t);
                end else begin
                    e = bq.pop_front();
                    check("b_ack_cycle", t, e[64:33]);
                    check("b_rdata", b_rdata, e[31:0]);
                end
            end else if (bq.size() > 0 && int'(bq[0][64:33]) <= t) begin
                e = bq.pop_front();
                n_vec++; n_err++;
                $display("FAIL b_missing_ack: got none expected ack due cycle %0d", e[64:33]);
            end
        end
        check("b_issued", k, 32'd8);
        check("b_drained", bq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
